rule_scan_sequencer: RTL and testbench
======================================

Name: rule_scan_sequencer

Overview:
- Upstream index generator for the fuzzy rule-decode stage.
- Walks the rule index space 0..NUM_RULES-1 and skips rules that are masked off.
- Drives the 3-bit index bus into the 3-to-8 rule decoder and holds it until the downstream rule evaluator acknowledges.
- Reports completion, the count of evaluated rules, and a sticky timeout error.

Parameters:
- NUM_RULES, 8, number of rule slots scanned (legal 1..8); indices >= NUM_RULES are never issued.
- TIMEOUT, 15, cycles valid may stay high without ack before the rule is abandoned (legal 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- rule_mask  input  8  per-rule enable; bit i=1 means rule i is evaluated; latched on accepted start.
- ack  input  1  evaluator has consumed the current index; meaningful only while valid=1.
- w  output  3  current rule index to the decoder.
- valid  output  1  w holds a rule to evaluate.
- busy  output  1  scan in progress (any state other than IDLE).
- done  output  1  one-cycle pulse at end of scan.
- err  output  1  sticky; set when any rule timed out in the current scan.
- count  output  4  number of rules acknowledged in the current or last scan.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; mask_r=0, idx=0, wait counter=0. All outputs 0: w, valid, busy, done, err, count.
- Reset asserted mid-scan aborts the scan immediately, with no done pulse.
- All outputs are registered.
- States: IDLE, FIND, ISSUE, DONE.
- IDLE:
  - start=1 -> latch rule_mask into mask_r; idx=0, count=0, err=0; go to FIND.
  - start while not in IDLE is ignored; there is no queuing.
- FIND, one cycle per index:
  - If mask_r[idx]=1 -> go to ISSUE; w=idx, valid=1, wait counter=0.
  - Else if idx==NUM_RULES-1 -> go to DONE.
  - Else idx=idx+1 and stay in FIND.
- ISSUE:
  - valid=1, and w is held stable.
  - ack=1 at an edge -> count=count+1; valid=0 next cycle.
  - Otherwise, if wait counter==TIMEOUT-1 -> err=1; rule abandoned without incrementing count; valid=0 next cycle. valid is therefore high exactly TIMEOUT cycles.
  - Otherwise wait counter +1.
  - After ack or abandon: go to DONE if idx==NUM_RULES-1, else idx=idx+1 and go to FIND.
  - ack and timeout at the same edge: ack wins, err unchanged.
- DONE: done=1 for exactly one cycle; busy=1 during DONE; go to IDLE next cycle.
- ack outside ISSUE is ignored.
- Hold behaviour in IDLE:
  - w keeps its last issued value, but is don't-care while valid=0.
  - count and err hold until the next accepted start.
- Latency:
  - With rule_mask[0]=1, valid rises 2 cycles after the start edge (IDLE->FIND, FIND->ISSUE).
  - Each enabled rule costs 1 FIND cycle plus the ISSUE cycles; each disabled rule costs 1 FIND cycle.
- rule_mask changes during a scan have no effect.
- count is wide enough for 8; there is no wrap.

Test Plan:
- Full mask, immediate ack: reset, then start with rule_mask=0xFF, NUM_RULES=8, ack high whenever valid=1 -> w sequence 0,1,…,7, each valid for 1 cycle. done pulses once 17 cycles after start, then count=8, err=0, busy=0.
- Empty mask: rule_mask=0x00 -> valid never rises; 8 FIND cycles, then done pulses; count=0.
- Sparse mask: rule_mask=0x81 with ack delayed 3 cycles -> w=0 held 4 cycles, then w=7 held 4 cycles; count=2.
- Timeout: TIMEOUT=4, rule_mask=0x07, ack withheld on rule 1 -> valid high on w=1 for exactly 4 cycles; err=1; rule 2 still issued; final count=2. A new start clears err.
- Ack/timeout collision: TIMEOUT=4, ack arrives on the 4th ISSUE cycle -> count increments, err stays 0.
- Reset, busy start, and NUM_RULES=5:
  - Reset asserted mid-ISSUE -> valid, busy, count, err go to 0 without waiting for a clock edge; no done pulse.
  - A second start while busy is ignored.
  - NUM_RULES=5 with rule_mask=0xFF -> w issues 0..4 only; count=5.

Source files
------------

// File: rtl/rule_scan_sequencer.sv
// Rule index sequencer: walks rule slots 0..NUM_RULES-1, skips masked rules, and
// holds each enabled index on w until the evaluator acks or the wait times out.
module rule_scan_sequencer #(
  parameter int NUM_RULES = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rule_mask,
  input  logic       ack,
  output logic [2:0] w,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] count
);

  typedef enum logic [1:0] {IDLE, FIND, ISSUE, DONE} state_t;

  localparam logic [2:0] LAST_IDX  = 3'(NUM_RULES - 1);
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] mask_r, mask_n;
  logic [2:0] idx, idx_n;
  logic [7:0] wait_cnt, wait_n;
  logic [2:0] w_n;
  logic       valid_n, busy_n, done_n, err_n;
  logic [3:0] count_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mask_r   <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      w        <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_n;
      mask_r   <= mask_n;
      idx      <= idx_n;
      wait_cnt <= wait_n;
      w        <= w_n;
      valid    <= valid_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      count    <= count_n;
    end
  end

  // Every output is computed one cycle ahead so the registered copy lines up with the state.
  always_comb begin
    state_n = state;
    mask_n  = mask_r;
    idx_n   = idx;
    wait_n  = wait_cnt;
    w_n     = w;
    valid_n = 1'b0;
    err_n   = err;
    count_n = count;
    case (state)
      IDLE: begin
        if (start) begin
          mask_n  = rule_mask;
          idx_n   = '0;
          count_n = '0;
          err_n   = 1'b0;
          state_n = FIND;
        end
      end
      FIND: begin
        if (mask_r[idx]) begin
          state_n = ISSUE;
          w_n     = idx;
          valid_n = 1'b1;
          wait_n  = '0;
        end else if (idx == LAST_IDX) begin
          state_n = DONE;
        end else begin
          idx_n = idx + 3'd1;
        end
      end
      ISSUE: begin
        // ack takes priority over an expiring wait on the same edge.
        if (ack || wait_cnt == LAST_WAIT) begin
          if (ack) count_n = count + 4'd1;
          else     err_n   = 1'b1;
          if (idx == LAST_IDX) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + 3'd1;
            state_n = FIND;
          end
        end else begin
          valid_n = 1'b1;
          wait_n  = wait_cnt + 8'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    done_n = (state_n == DONE);
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_rule_scan_sequencer.sv
// Randomized scoreboard bench for rule_scan_sequencer (NUM_RULES=5, TIMEOUT=4): a
// cycle-cost model predicts every issued index, its hold time and the scan summary.
module tb_rule_scan_sequencer;

  localparam int NR = 5;
  localparam int TO = 4;

  typedef struct {
    int idx;
    int hold;
    int rise;
  } issue_t;

  typedef struct {
    int cnt;
    int err;
    int at;
  } scan_t;

  logic       clk = 1'b0;
  logic       rst, start, ack;
  logic [7:0] rule_mask;
  logic [2:0] w;
  logic       valid, busy, done, err;
  logic [3:0] count;

  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  int     ack_delay [8];
  issue_t issue_q [$];
  scan_t  scan_q [$];

  rule_scan_sequencer #(.NUM_RULES(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .rule_mask(rule_mask), .ack(ack),
    .w(w), .valid(valid), .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic failNow(input string name);
    n_checks++;
    $display("[TB] FAIL %s: event not expected or never arrived (cycle %0d)", name, cyc);
  endtask

  // Evaluator model: ack after ack_delay[w] held cycles; random ack noise while idle.
  initial begin
    int vrun;
    ack  = 1'b0;
    vrun = 0;
    forever begin
      @(negedge clk);
      if (rst || !valid) begin
        vrun = 0;
        ack  = 1'($urandom_range(0, 1));
      end else begin
        ack = (vrun >= ack_delay[w]);
        vrun++;
      end
    end
  end

  // Monitor: pops one record per valid rise and one per done pulse.
  initial begin
    issue_t cur;
    scan_t  sc;
    int     run, last_count, last_err;
    bit     prev_valid;
    cur = '{idx: 0, hold: 0, rise: 0};
    run = 0; last_count = 0; last_err = 0; prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0; run = 0; last_count = 0; last_err = 0;
      end else begin
        if (valid) begin
          if (!prev_valid) begin
            run = 0;
            if (issue_q.size() == 0) failNow("unexpected_issue");
            else begin
              cur = issue_q.pop_front();
              checkOutput("rise_cycle", cyc, cur.rise);
            end
          end
          run++;
          checkOutput("w_index", int'(w), cur.idx);
          checkOutput("busy_in_issue", int'(busy), 1);
          if (run == cur.hold + 1) failNow("valid_overrun");
        end else if (prev_valid) begin
          checkOutput("valid_len", run, cur.hold);
        end
        if (done) begin
          if (scan_q.size() == 0) failNow("unexpected_done");
          else begin
            sc = scan_q.pop_front();
            checkOutput("done_cycle", cyc, sc.at);
            checkOutput("scan_count", int'(count), sc.cnt);
            checkOutput("scan_err", int'(err), sc.err);
            checkOutput("busy_in_done", int'(busy), 1);
            last_count = sc.cnt;
            last_err   = sc.err;
          end
        end else if (!busy) begin
          checkOutput("idle_valid", int'(valid), 0);
          checkOutput("idle_count", int'(count), last_count);
          checkOutput("idle_err", int'(err), last_err);
        end
        prev_valid = valid;
      end
    end
  end

  // Predicts the scan from the mask and ack delays, then raises start for one cycle.
  task automatic launchScan(input logic [7:0] mask);
    int t, cnt, e, hold;
    @(negedge clk);
    for (int n = 0; busy && n < 100; n++) @(negedge clk);
    if (busy) begin
      failNow("idle_wait");
      return;
    end
    t = cyc + 1;
    cnt = 0;
    e = 0;
    for (int i = 0; i < NR; i++) begin
      if (mask[i]) begin
        hold = (ack_delay[i] < TO) ? ack_delay[i] + 1 : TO;
        issue_q.push_back('{idx: i, hold: hold, rise: t + 1});
        t += 1 + hold;
        if (ack_delay[i] < TO) cnt++;
        else e = 1;
      end else begin
        t += 1;
      end
    end
    scan_q.push_back('{cnt: cnt, err: e, at: t});
    start = 1'b1;
    rule_mask = mask;
    @(negedge clk);
    start = 1'b0;
    rule_mask = 8'($urandom);
  endtask

  task automatic awaitScan(input bit poke_busy);
    int n;
    for (n = 0; scan_q.size() != 0 && n < 200; n++) begin
      if (poke_busy && n == 2) begin
        start = 1'b1;
        rule_mask = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (scan_q.size() != 0) begin
      failNow("scan_timeout");
      issue_q.delete();
      scan_q.delete();
    end
  endtask

  task automatic applyStimulus(input logic [7:0] mask, input bit poke_busy);
    launchScan(mask);
    awaitScan(poke_busy);
  endtask

  task automatic setDelays(input int d);
    for (int i = 0; i < 8; i++) ack_delay[i] = d;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rule_mask = 8'h00;
    setDelays(0);
    repeat (3) @(negedge clk);
    checkOutput("reset_w", int'(w), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_count", int'(count), 0);
    rst = 1'b0;

    $display("[TB] full mask, immediate ack");
    applyStimulus(8'hFF, 1'b0);
    $display("[TB] empty mask");
    applyStimulus(8'h00, 1'b0);
    $display("[TB] sparse mask, ack on last allowed cycle");
    setDelays(TO - 1);
    applyStimulus(8'h11, 1'b0);
    $display("[TB] mask bits above NUM_RULES");
    setDelays(2);
    applyStimulus(8'hE1, 1'b0);
    $display("[TB] timeout on rule 1, then err clears");
    setDelays(0);
    ack_delay[1] = TO + 3;
    applyStimulus(8'h07, 1'b0);
    setDelays(0);
    applyStimulus(8'h01, 1'b0);
    $display("[TB] start while busy");
    setDelays(1);
    applyStimulus(8'h0A, 1'b1);

    $display("[TB] random scans");
    for (int s = 0; s < 24; s++) begin
      for (int i = 0; i < 8; i++) ack_delay[i] = $urandom_range(0, TO + 1);
      applyStimulus(8'($urandom), s[0]);
    end

    $display("[TB] reset during issue");
    setDelays(TO + 3);
    ack_delay[0] = 0;
    launchScan(8'h07);
    for (int n = 0; !(valid && w == 3'd2) && n < 60; n++) @(negedge clk);
    if (!(valid && w == 3'd2)) failNow("reach_rule2");
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", int'(valid), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_count", int'(count), 0);
    checkOutput("async_rst_err", int'(err), 0);
    checkOutput("async_rst_done", int'(done), 0);
    issue_q.delete();
    scan_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    setDelays(0);
    applyStimulus(8'h1F, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("leftover_issues", issue_q.size(), 0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
